rca_result_packer: RTL and testbench

RCA_RESULT_PACKER -- requirements
Module: rca_result_packer

---
 rtl/rca_pkg.sv | 20 ++
 rtl/rca_fifo2.sv | 63 ++++++
 rtl/rca_result_packer.sv | 103 ++++++++++
 tb/tb_rca_result_packer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared ripple-carry adder and result packer width constants
package rca_pkg;

  // Operand/sum width of one ripple-carry adder slice
  localparam int ADDER_W = 4;
  // Carry-out width of one adder slice
  localparam int CARRY_W = 1;

  // Packer defaults: one nibble per adder result, four nibbles per word
  localparam int SUM_W_DEF   = ADDER_W;
  localparam int NIBBLES_DEF = 4;

  // Assembled word width is always derived, never set independently
  function automatic int word_w(input int sum_w, input int nibbles);
    return sum_w * nibbles;
  endfunction

  localparam int WORD_W_DEF = word_w(SUM_W_DEF, NIBBLES_DEF);

endpackage

// File: rtl/rca_fifo2.sv
// rtl/rca_fifo2.sv - two-entry registered output FIFO for assembled words
module rca_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;

  // Head is always a register so the consumer sees a stable word while stalled.
  // Push into a full FIFO without a pop is ignored; the caller counts the drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (push) begin
            r_head  <= push_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            r_head <= push_data;
          end else if (push) begin
            r_tail  <= push_data;
            r_count <= 2'd2;
          end else if (pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            r_head <= r_tail;
            if (push) begin
              r_tail <= push_data;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

  assign full      = (r_count == 2'd2);
  assign empty     = (r_count == 2'd0);
  assign head_data = r_head;

endmodule

// File: rtl/rca_result_packer.sv
// rtl/rca_result_packer.sv - packs adder result nibbles into words behind a 2-entry FIFO
module rca_result_packer
  import rca_pkg::*;
#(
  parameter  int SUM_W   = SUM_W_DEF,
  parameter  int NIBBLES = NIBBLES_DEF,
  localparam int WORD_W  = word_w(SUM_W, NIBBLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [SUM_W-1:0]  in_sum,
  input  logic              in_cout,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_cout,
  output logic              drop_err,
  output logic [7:0]        drop_cnt
);

  localparam int              IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_asm;
  logic              r_drop_err;
  logic [7:0]        r_drop_cnt;

  logic              w_last;
  logic              w_complete;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W:0]   w_head;

  // A flushed cycle never completes a word, even if it carries the last nibble
  assign w_last     = (r_idx == LAST_IDX);
  assign w_complete = in_valid && !in_flush && w_last;
  assign w_pop      = !w_empty && out_ready;
  // A pop on the same edge frees the slot the new word needs
  assign w_push     = w_complete && (!w_full || w_pop);
  assign w_drop     = w_complete && w_full && !w_pop;

  // Completed word: assembly so far with the final nibble merged into its slot
  always_comb begin
    w_word = r_asm;
    w_word[int'(r_idx) * SUM_W +: SUM_W] = in_sum;
  end

  // Nibble index and assembly register; cleared on wrap so unwritten bits read zero
  always_ff @(posedge clk) begin
    if (rst || in_flush) begin
      r_idx <= '0;
      r_asm <= '0;
    end else if (in_valid) begin
      if (w_last) begin
        r_idx <= '0;
        r_asm <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
        r_asm[int'(r_idx) * SUM_W +: SUM_W] <= in_sum;
      end
    end
  end

  // Sticky drop flag and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_err <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_drop_err <= 1'b1;
      if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  rca_fifo2 #(
    .DATA_W (WORD_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({in_cout, w_word}),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head_data (w_head)
  );

  assign out_valid = !w_empty;
  assign out_word  = w_head[WORD_W-1:0];
  assign out_cout  = w_head[WORD_W];
  assign drop_err  = r_drop_err;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_rca_result_packer.sv
// tb/tb_rca_result_packer.sv - directed self-checking bench for rca_result_packer
module tb_rca_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_sum;
  logic        in_cout;
  logic        in_flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic        out_cout;
  logic        drop_err;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  rca_result_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_cout  (out_cout),
    .drop_err  (drop_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nib(input logic [3:0] s, input logic c, input logic rdy);
    in_valid  = 1'b1;
    in_sum    = s;
    in_cout   = c;
    in_flush  = 1'b0;
    out_ready = rdy;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    in_valid  = 1'b0;
    in_flush  = 1'b0;
    out_ready = rdy;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = 4'h0; in_cout = 1'b0;
    in_flush = 1'b0; out_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_word",  out_word,  0);
    chk("rst_cout",  out_cout,  0);
    chk("rst_derr",  drop_err,  0);
    chk("rst_dcnt",  drop_cnt,  0);

    // Basic assembly, LSB nibble first, cout from final nibble, one-cycle latency
    nib(4'h1, 1'b0, 1'b1);
    nib(4'h2, 1'b0, 1'b1);
    nib(4'h3, 1'b0, 1'b1);
    chk("basic_not_yet", out_valid, 0);
    nib(4'h4, 1'b1, 1'b1);
    chk("basic_valid", out_valid, 1);
    chk("basic_word",  out_word,  32'h4321);
    chk("basic_cout",  out_cout,  1);
    idle(1'b1);
    chk("basic_popped", out_valid, 0);

    // Overflow: two words buffered, third dropped, then drained in order
    for (int i = 0; i < 12; i++) nib(4'(i), 1'b0, 1'b0);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_head",  out_word,  32'h3210);
    chk("ovf_derr",  drop_err,  1);
    chk("ovf_dcnt",  drop_cnt,  1);
    idle(1'b1);
    chk("ovf_second_valid", out_valid, 1);
    chk("ovf_second_word",  out_word,  32'h7654);
    idle(1'b1);
    chk("ovf_drained", out_valid, 0);

    // Full FIFO with pop on the completing edge: accepted, no drop
    do_reset();
    for (int i = 1; i <= 8; i++) nib(4'(i), 1'b0, 1'b0);
    nib(4'h9, 1'b0, 1'b0);
    nib(4'hA, 1'b0, 1'b0);
    nib(4'hB, 1'b0, 1'b0);
    nib(4'hC, 1'b1, 1'b1);
    chk("fullpop_valid", out_valid, 1);
    chk("fullpop_head",  out_word,  32'h8765);
    chk("fullpop_dcnt",  drop_cnt,  0);
    chk("fullpop_derr",  drop_err,  0);
    idle(1'b1);
    chk("fullpop_new_word", out_word, 32'hCBA9);
    chk("fullpop_new_cout", out_cout, 1);
    idle(1'b1);
    chk("fullpop_drained", out_valid, 0);

    // Flush discards partial word and the nibble presented with it
    nib(4'hA, 1'b0, 1'b0);
    nib(4'hB, 1'b0, 1'b0);
    in_valid = 1'b1; in_sum = 4'hC; in_flush = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_flush = 1'b0;
    nib(4'h1, 1'b0, 1'b0);
    nib(4'h2, 1'b0, 1'b0);
    nib(4'h3, 1'b0, 1'b0);
    chk("flush_not_yet", out_valid, 0);
    nib(4'h4, 1'b0, 1'b0);
    chk("flush_valid", out_valid, 1);
    chk("flush_word",  out_word,  32'h4321);
    chk("flush_dcnt",  drop_cnt,  0);
    idle(1'b1);
    chk("flush_single", out_valid, 0);

    // Reset mid-word with buffered words and a prior drop
    for (int i = 0; i < 12; i++) nib(4'(i), 1'b0, 1'b0);
    chk("rst2_pre_dcnt", drop_cnt, 1);
    nib(4'h9, 1'b0, 1'b0);
    nib(4'h9, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_sum = 4'h9; in_flush = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_flush = 1'b0;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_dcnt",  drop_cnt,  0);
    chk("rst2_derr",  drop_err,  0);
    chk("rst2_word",  out_word,  0);
    nib(4'h5, 1'b0, 1'b0);
    nib(4'h6, 1'b0, 1'b0);
    nib(4'h7, 1'b0, 1'b0);
    nib(4'h8, 1'b0, 1'b0);
    chk("rst2_new_valid", out_valid, 1);
    chk("rst2_new_word",  out_word,  32'h8765);
    idle(1'b1);
    chk("rst2_drained", out_valid, 0);

    // 300 drops: counter saturates at 255 and holds
    for (int w = 0; w < 302; w++) begin
      for (int k = 0; k < 4; k++) nib(4'(w + 1), 1'b0, 1'b0);
      if (w == 255) chk("sat_254", drop_cnt, 254);
      if (w == 256) chk("sat_255", drop_cnt, 255);
    end
    chk("sat_final_dcnt", drop_cnt, 255);
    chk("sat_final_derr", drop_err, 1);
    chk("sat_head",       out_word, 32'h1111);
    idle(1'b0);
    chk("sat_hold_dcnt",  drop_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
